// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort detection on an 8-bit history window,
// zero deletion and LSB-first byte assembly on the bit leaving the window.
module hdlc_rx_framer #(
  parameter int MAX_FRAME  = 128,
  parameter int ABORT_ONES = 7,
  localparam int SIZE_W    = $clog2(MAX_FRAME + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx,
  input  logic              RxEN,
  output logic [7:0]        Rx_Data,
  output logic              Rx_NewByte,
  output logic              Rx_ValidFrame,
  output logic              Rx_FlagDetect,
  output logic              Rx_AbortDetect,
  output logic              Rx_EoF,
  output logic              Rx_FrameError,
  output logic              Rx_Overflow,
  output logic [SIZE_W-1:0] Rx_FrameSize
);

  typedef enum logic {HUNT, FRAME} state_t;

  localparam logic [SIZE_W-1:0] MAX_CNT = SIZE_W'(MAX_FRAME);

  state_t              state, stateN;
  logic [7:0]          hist, histN;      // newest bit at [7]
  logic [7:0]          histVld, vldN;    // marks history bits that are data, not flag
  logic [7:0]          shReg, shN;
  logic [2:0]          bitCnt, bitN;
  logic [SIZE_W-1:0]   byteCnt, byteN;
  logic [2:0]          onesCnt, onesN;
  logic                seen, seenN;      // a data bit accepted since the last flag
  logic [7:0]          dataN;
  logic [SIZE_W-1:0]   sizeN;
  logic                errN, ovfN, nbN, flagN, abortN, eofN;
  logic                dBit, dVld, accept, isFlag, isAbort;

  assign Rx_ValidFrame = (state == FRAME) && seen;

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= HUNT;
      hist           <= '0;
      histVld        <= '0;
      shReg          <= '0;
      bitCnt         <= '0;
      byteCnt        <= '0;
      onesCnt        <= '0;
      seen           <= 1'b0;
      Rx_Data        <= '0;
      Rx_FrameSize   <= '0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_EoF         <= 1'b0;
    end else begin
      state          <= stateN;
      hist           <= histN;
      histVld        <= vldN;
      shReg          <= shN;
      bitCnt         <= bitN;
      byteCnt        <= byteN;
      onesCnt        <= onesN;
      seen           <= seenN;
      Rx_Data        <= dataN;
      Rx_FrameSize   <= sizeN;
      Rx_FrameError  <= errN;
      Rx_Overflow    <= ovfN;
      Rx_NewByte     <= nbN;
      Rx_FlagDetect  <= flagN;
      Rx_AbortDetect <= abortN;
      Rx_EoF         <= eofN;
    end
  end

  // Next-state: data bit first, then flag/abort so a byte finishing on the
  // flag's last bit is counted in the closing frame
  always_comb begin
    stateN  = state;
    histN   = hist;
    vldN    = histVld;
    shN     = shReg;
    bitN    = bitCnt;
    byteN   = byteCnt;
    onesN   = onesCnt;
    seenN   = seen;
    dataN   = Rx_Data;
    sizeN   = Rx_FrameSize;
    errN    = Rx_FrameError;
    ovfN    = Rx_Overflow;
    nbN     = 1'b0;
    flagN   = 1'b0;
    abortN  = 1'b0;
    eofN    = 1'b0;
    dBit    = hist[0];
    dVld    = histVld[0];
    accept  = 1'b0;
    isFlag  = 1'b0;
    isAbort = 1'b0;

    if (RxEN) begin
      histN   = {Rx, hist[7:1]};
      vldN    = {1'b1, histVld[7:1]};
      isFlag  = (histN == 8'h7E);
      isAbort = &histN[7:8-ABORT_ONES];
      flagN   = isFlag;
      abortN  = isAbort;

      if (state == FRAME && isAbort) begin
        // drop the partial frame; the next flag reinitialises everything
        stateN = HUNT;
        seenN  = 1'b0;
      end else if (state == FRAME) begin
        if (dVld) begin
          if (dBit) begin
            accept = 1'b1;
            if (onesCnt != 3'd7) onesN = onesCnt + 3'd1;
          end else begin
            accept = (onesCnt != 3'd5);   // stuffed zero is dropped
            onesN  = 3'd0;
          end
          if (accept) begin
            seenN = 1'b1;
            shN   = {dBit, shReg[7:1]};
            if (bitCnt == 3'd7) begin
              bitN = 3'd0;
              if (byteCnt == MAX_CNT) begin
                ovfN = 1'b1;
              end else begin
                byteN = byteCnt + SIZE_W'(1);
                dataN = shN;
                nbN   = 1'b1;
              end
            end else begin
              bitN = bitCnt + 3'd1;
            end
          end
        end
        if (isFlag) begin
          if (byteN != '0 || bitN != 3'd0) begin
            eofN  = 1'b1;
            sizeN = byteN;
            errN  = (bitN != 3'd0);
          end
          byteN = '0;
          bitN  = 3'd0;
          onesN = 3'd0;
          ovfN  = 1'b0;
          seenN = 1'b0;
          vldN  = '0;
        end
      end else if (isFlag) begin
        stateN = FRAME;
        byteN  = '0;
        bitN   = 3'd0;
        onesN  = 3'd0;
        ovfN   = 1'b0;
        seenN  = 1'b0;
        vldN   = '0;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Scoreboard bench: two framers (MAX_FRAME 128 and 4) share one serial line.
module tb_hdlc_rx_framer;

  typedef struct packed {
    logic       nb;
    logic [7:0] d;
    logic       eof;
    logic [7:0] size;
    logic       err;
    logic       ab;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b0;
  logic rxEn = 1'b0;

  logic [7:0] dataA, dataB;
  logic nbA, validA, flagA, abA, eofA, errA, ovfA;
  logic nbB, validB, flagB, abB, eofB, errB, ovfB;
  logic [7:0] sizeA;
  logic [2:0] sizeB;

  int total = 0;
  int passed = 0;
  int flagsSent = 0;
  int flagCntA = 0;
  int flagCntB = 0;
  bit ovfSeenA = 0;
  bit ovfSeenB = 0;

  evt_t qA[$];
  evt_t qB[$];
  logic bq[$];

  always #5 clk = ~clk;

  hdlc_rx_framer #(.MAX_FRAME(128), .ABORT_ONES(7)) dutA (
    .Clk(clk), .Rst(rst), .Rx(rx), .RxEN(rxEn),
    .Rx_Data(dataA), .Rx_NewByte(nbA), .Rx_ValidFrame(validA),
    .Rx_FlagDetect(flagA), .Rx_AbortDetect(abA), .Rx_EoF(eofA),
    .Rx_FrameError(errA), .Rx_Overflow(ovfA), .Rx_FrameSize(sizeA)
  );

  hdlc_rx_framer #(.MAX_FRAME(4), .ABORT_ONES(7)) dutB (
    .Clk(clk), .Rst(rst), .Rx(rx), .RxEN(rxEn),
    .Rx_Data(dataB), .Rx_NewByte(nbB), .Rx_ValidFrame(validB),
    .Rx_FlagDetect(flagB), .Rx_AbortDetect(abB), .Rx_EoF(eofB),
    .Rx_FrameError(errB), .Rx_Overflow(ovfB), .Rx_FrameSize(sizeB)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic evCheck(input string tag, input evt_t got, input evt_t exp);
    bit ok;
    ok = (got.nb == exp.nb) && (got.eof == exp.eof) && (got.ab == exp.ab) &&
         (!exp.nb || got.d == exp.d) &&
         (!exp.eof || (got.size == exp.size && got.err == exp.err));
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got nb=%0b d=%02h eof=%0b size=%0d err=%0b ab=%0b, expected nb=%0b d=%02h eof=%0b size=%0d err=%0b ab=%0b",
                  tag, got.nb, got.d, got.eof, got.size, got.err, got.ab,
                  exp.nb, exp.d, exp.eof, exp.size, exp.err, exp.ab);
  endtask

  // Monitor for the 128-byte framer
  initial forever begin
    evt_t got;
    @(negedge clk);
    if (!rst) begin
      if (flagA) flagCntA++;
      if (ovfA) ovfSeenA = 1;
      if (nbA || eofA || abA) begin
        got = '0;
        got.nb = nbA; got.d = dataA; got.eof = eofA;
        got.size = sizeA; got.err = errA; got.ab = abA;
        if (qA.size() == 0) begin
          total++;
          $display("FAIL evtA unexpected: got nb=%0b d=%02h eof=%0b ab=%0b, expected no event", nbA, dataA, eofA, abA);
        end else evCheck("evtA", got, qA.pop_front());
      end
    end
  end

  // Monitor for the 4-byte framer
  initial forever begin
    evt_t got;
    @(negedge clk);
    if (!rst) begin
      if (flagB) flagCntB++;
      if (ovfB) ovfSeenB = 1;
      if (nbB || eofB || abB) begin
        got = '0;
        got.nb = nbB; got.d = dataB; got.eof = eofB;
        got.size = 8'(sizeB); got.err = errB; got.ab = abB;
        if (qB.size() == 0) begin
          total++;
          $display("FAIL evtB unexpected: got nb=%0b d=%02h eof=%0b ab=%0b, expected no event", nbB, dataB, eofB, abB);
        end else evCheck("evtB", got, qB.pop_front());
      end
    end
  end

  task automatic sendBit(input logic b, input int gap);
    rx = b;
    rxEn = 1'b1;
    @(posedge clk); #1;
    rxEn = 1'b0;
    rx = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic sendFlag(input int gap);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) sendBit(f[i], gap);
    flagsSent++;
  endtask

  task automatic addByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bq.push_back(b[i]);
  endtask

  task automatic pushEvt(input bit toA, input evt_t e);
    if (toA) qA.push_back(e);
    else qB.push_back(e);
  endtask

  // Expected events for one frame held in bq, for a framer limited to lim bytes
  task automatic pushExp(input int lim, input bit toA, input bit coincOk);
    int nBits, nBytes, rem, emit;
    bit merged;
    evt_t e;
    nBits = bq.size();
    nBytes = nBits / 8;
    rem = nBits % 8;
    emit = (nBytes < lim) ? nBytes : lim;
    merged = 0;
    for (int i = 0; i < emit; i++) begin
      e = '0;
      e.nb = 1'b1;
      for (int k = 0; k < 8; k++) e.d[k] = bq[8*i+k];
      if (i == nBytes - 1 && rem == 0 && coincOk) begin
        e.eof = 1'b1;
        e.size = 8'(emit);
        merged = 1;
      end
      pushEvt(toA, e);
    end
    if (!merged && nBits > 0) begin
      e = '0;
      e.eof = 1'b1;
      e.size = 8'(emit);
      e.err = (rem != 0);
      pushEvt(toA, e);
    end
  endtask

  // Flag, zero-stuffed contents of bq, flag
  task automatic sendFrame(input int gap);
    logic sq[$];
    int ones;
    bit lastStuffed;
    ones = 0;
    lastStuffed = 0;
    foreach (bq[i]) begin
      sq.push_back(bq[i]);
      lastStuffed = 0;
      if (bq[i]) ones++;
      else ones = 0;
      if (ones == 5) begin
        sq.push_back(1'b0);
        ones = 0;
        lastStuffed = 1;
      end
    end
    pushExp(128, 1, !lastStuffed);
    pushExp(4, 0, !lastStuffed);
    sendFlag(gap);
    foreach (sq[i]) sendBit(sq[i], gap);
    sendFlag(gap);
    bq.delete();
  endtask

  initial begin
    evt_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("reset validA", 32'(validA), 0);
    chk("reset dataA", 32'(dataA), 0);
    chk("reset strobesA", 32'({nbA, flagA, abA, eofA, errA, ovfA}), 0);
    chk("reset sizeA", 32'(sizeA), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // two bytes, byte-aligned
    addByte(8'hA5); addByte(8'h3C);
    sendFrame(0);
    // same frame with RxEN 1-in-3
    addByte(8'hA5); addByte(8'h3C);
    sendFrame(2);
    // 0xFF needs a stuffed zero
    addByte(8'hFF);
    sendFrame(0);
    // 12 bits: one byte plus a 4-bit remainder
    addByte(8'h5A);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
    sendFrame(0);
    // six bytes: overflows the 4-byte framer only
    for (int i = 1; i <= 6; i++) addByte(8'(i));
    sendFrame(0);
    chk("overflow seen B", 32'(ovfSeenB), 1);
    chk("overflow seen A", 32'(ovfSeenA), 0);

    // abort mid-frame: 0x12 never completes because only 7 of its bits leave the window
    e = '0;
    e.ab = 1'b1;
    qA.push_back(e);
    qB.push_back(e);
    sendFlag(0);
    addByte(8'h12);
    foreach (bq[i]) sendBit(bq[i], 0);
    bq.delete();
    repeat (7) sendBit(1'b1, 0);
    sendBit(1'b0, 0);
    @(posedge clk); #1;
    chk("abort validA", 32'(validA), 0);
    chk("abort validB", 32'(validB), 0);

    // reset mid-frame
    sendFlag(0);
    addByte(8'h55);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1);
    foreach (bq[i]) sendBit(bq[i], 0);
    bq.delete();
    chk("midframe validA", 32'(validA), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst validA", 32'(validA), 0);
    chk("rst dataA", 32'(dataA), 0);
    chk("rst outsA", 32'({nbA, flagA, abA, eofA, errA, ovfA, sizeA}), 0);
    chk("rst outsB", 32'({validB, dataB, nbB, flagB, abB, eofB, errB, ovfB, sizeB}), 0);
    rst = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    chk("queue A drained", 32'(qA.size()), 0);
    chk("queue B drained", 32'(qB.size()), 0);
    chk("flag count A", 32'(flagCntA), 32'(flagsSent));
    chk("flag count B", 32'(flagCntB), 32'(flagsSent));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_framer.md
HDLC_RX_FRAMER -- requirements
Module: hdlc_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME, default 128, meaning maximum data bytes per frame (range 2..255).
REQ-002 SHALL have parameter ABORT_ONES, default 7, meaning consecutive 1s that signal abort (range 7..8).
REQ-003 SHALL derive localparam SIZE_W = clog2(MAX_FRAME+1), meaning the width of the size counter.
REQ-004 SHALL have one clock, Clk; all state updates on its rising edge.
REQ-005 SHALL have port Clk  in  1  system clock.
REQ-006 SHALL have port Rst  in  1  reset; reset is synchronous and active-high.
REQ-007 SHALL have port Rx  in  1  serial line bit, sampled only when RxEN=1.
REQ-008 SHALL have port RxEN  in  1  bit-valid strobe; one Rx bit per cycle with RxEN=1.
REQ-009 SHALL have port Rx_Data  out  8  last assembled byte, LSB received first.
REQ-010 SHALL have port Rx_NewByte  out  1  one-cycle strobe: Rx_Data valid.
REQ-011 SHALL have port Rx_ValidFrame  out  1  high while inside a frame.
REQ-012 SHALL have port Rx_FlagDetect  out  1  one-cycle strobe on flag 01111110.
REQ-013 SHALL have port Rx_AbortDetect  out  1  one-cycle strobe on abort pattern.
REQ-014 SHALL have port Rx_EoF  out  1  one-cycle strobe: frame closed.
REQ-015 SHALL have port Rx_FrameError  out  1  valid with Rx_EoF: bit count not a multiple of 8.
REQ-016 SHALL have port Rx_Overflow  out  1  sticky: frame exceeded MAX_FRAME.
REQ-017 SHALL have port Rx_FrameSize  out  SIZE_W  data bytes in the closed frame, valid with Rx_EoF.

Function
REQ-018 SHALL shift Rx into an 8-bit history register on every RxEN=1 cycle; no state changes when RxEN=0, except that strobes clear.
REQ-019 SHALL evaluate flag and abort detection on the updated history and register the strobe one cycle after the sampling cycle.
REQ-020 SHALL treat the bit shifted out of the history as the data-path bit, so flag bits never reach the byte assembler.
REQ-021 SHALL use an FSM with states HUNT (reset state) and FRAME.
REQ-022 SHALL, in HUNT, ignore data bits; flag -> FRAME, clearing the byte count, bit count, ones count and Rx_Overflow.
REQ-023 SHALL, in FRAME, delete a data-path 0 that follows exactly five consecutive data-path 1s (zero deletion); such a deleted 0 is not counted.
REQ-024 SHALL assemble non-deleted data bits LSB-first and pulse Rx_NewByte on the cycle after the 8th bit; Rx_Data holds until the next byte.
REQ-025 SHALL, on a flag in FRAME with byte count 0 and bit count 0, stay in FRAME with no Rx_EoF (shared/back-to-back flags).
REQ-026 SHALL, on a flag in FRAME with byte count >0, pulse Rx_EoF, set Rx_FrameSize to the byte count, set Rx_FrameError = (bit count != 0), and restart FRAME as if for an opening flag.
REQ-027 SHALL, on a flag with byte count 0 and bit count != 0, pulse Rx_EoF with Rx_FrameSize=0 and Rx_FrameError=1.
REQ-028 SHALL, on abort (ABORT_ONES ones in history) in FRAME, pulse Rx_AbortDetect, go to HUNT, and emit no Rx_EoF and no partial byte.
REQ-029 SHALL, on abort in HUNT, pulse Rx_AbortDetect only.
REQ-030 SHALL, for a byte completing when byte count = MAX_FRAME, set Rx_Overflow, suppress Rx_NewByte and hold the count; later bytes are also suppressed.
REQ-031 SHALL, on the closing flag after an overflow, give Rx_EoF with Rx_FrameSize = MAX_FRAME.
REQ-032 SHALL give flag priority when flag and byte completion coincide; a byte completing in the same sampling cycle is emitted first (Rx_NewByte and Rx_EoF in the same cycle, with the count including that byte).
REQ-033 SHALL drive Rx_ValidFrame = 1 exactly while the FSM is in FRAME and at least one data bit has been accepted since the last flag.

Reset
REQ-034 SHALL, on Rst=1 at a clock edge, reset the FSM to HUNT; history, counters, Rx_Data and Rx_FrameSize to 0; all strobes, Rx_ValidFrame, Rx_FrameError and Rx_Overflow to 0.
REQ-035 SHALL give reset precedence over RxEN, and a reset mid-frame discards the frame silently.

Verification
REQ-036 SHALL cover: flag, 0xA5, 0x3C, flag with RxEN=1 -> Rx_NewByte twice (0xA5, 0x3C), Rx_EoF, Rx_FrameSize=2, Rx_FrameError=0.
REQ-037 SHALL cover: flag, 0xFF (with stuffed 0 after 5 ones), flag -> Rx_Data=0xFF, Rx_FrameSize=1, no spurious flag.
REQ-038 SHALL cover: flag, 0x12, then seven 1s -> Rx_AbortDetect pulse, no Rx_EoF, Rx_ValidFrame=0.
REQ-039 SHALL cover: MAX_FRAME=4; flag, 6 bytes, flag -> 4 Rx_NewByte, Rx_Overflow=1, Rx_FrameSize=4.
REQ-040 SHALL cover: flag, 12 data bits, flag -> Rx_EoF with Rx_FrameSize=1, Rx_FrameError=1.
REQ-041 SHALL cover: RxEN toggling 1-in-3 cycles during the REQ-036 frame -> identical byte and size results, and Rst mid-frame -> all outputs 0 and no Rx_EoF.
